// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, stop-bit check and a small
// circular FIFO drained through a valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on the synced input
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sample 8 data bits at mid-bit, LSB first
// STOP      | sample the stop bit; push on 1, flag frame error on 0
// WAIT_HIGH | after a bad stop bit, wait for the line to return high
module uart_rx_fifo #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600,
   parameter int DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     din,
   input  logic                     rx_ready,
   output logic [7:0]               rx_data,
   output logic                     rx_valid,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     frame_err,
   output logic                     overrun,
   output logic                     busy
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int HALF     = BAUD_DIV / 2;
   localparam int CW       = $clog2(BAUD_DIV);
   localparam int AW       = $clog2(DEPTH);

   localparam logic [CW-1:0] CNT_BIT  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          sync1, rxs;
   logic          stop_good;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;

   // Two-flop synchronizer; resets to the idle-high line level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= din;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         shift   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      stop_good = 1'b0;
      frame_err = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_nxt = '0;
               if (!rxs) begin
                  state_nxt = DATA;
                  bit_nxt   = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == CNT_BIT) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = rxs;
               bit_nxt            = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == CNT_BIT) begin
               cnt_nxt = '0;
               if (rxs) begin
                  stop_good = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (rxs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign rx_valid = (fifo_count != '0);
   assign pop      = rx_valid & rx_ready;
   // A full FIFO still accepts a byte when the head is popped in the same cycle.
   assign push     = stop_good & ((fifo_count != FULL) | pop);
   assign overrun  = stop_good & (fifo_count == FULL) & ~pop;
   assign rx_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= shift;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames
// checked against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

   localparam int CLK_FREQ = 16_000_000;
   localparam int BAUD     = 1_000_000;
   localparam int DEPTH    = 4;
   localparam int BD       = CLK_FREQ / BAUD;
   localparam int HALF     = BD / 2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   din = 1'b1;
   logic                   rx_ready = 1'b0;
   logic [7:0]             rx_data;
   logic                   rx_valid;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   frame_err;
   logic                   overrun;
   logic                   busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ferr_seen = 0;
   int ovr_seen = 0;
   int busy_seen = 0;
   int rise_cyc = -1;
   logic prev_valid = 1'b0;
   logic [7:0] q[$];

   uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .din(din), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
      .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
      if (busy) busy_seen++;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one full frame; optionally pulses rx_ready for the stop-sample cycle,
   // which lands 2 sync cycles past mid-stop-bit relative to the line.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop = 1'b0);
      din = 1'b0;
      tick(BD);
      for (int i = 0; i < 8; i++) begin
         din = b[i];
         tick(BD);
      end
      din = stop;
      if (pop_at_stop) begin
         tick(HALF + 2);
         rx_ready = 1'b1;
         tick(1);
         rx_ready = 1'b0;
         tick(BD - HALF - 3);
      end else begin
         tick(BD);
      end
   endtask

   task automatic pop_one(input logic [7:0] exp_b);
      chk("pop_valid", rx_valid, 1);
      chk("pop_data", rx_data, exp_b);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   initial begin
      int t0, b0, f0, o0, exp_f, exp_o, n;
      logic [7:0] rb, hb;
      logic good;

      tick(3);
      chk("rst_data", rx_data, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b1;
      tick(2);

      // single byte with latency: 2 sync + detect cycle + HALF + 9 bit times
      t0 = cyc;
      send_frame(8'hA5, 1'b1);
      tick(2);
      chk("lat_valid", rise_cyc - t0, 3 + HALF + 9 * BD);
      chk("single_count", fifo_count, 1);
      pop_one(8'hA5);
      chk("single_empty_valid", rx_valid, 0);
      chk("single_empty_count", fifo_count, 0);

      // glitch on the start bit
      b0 = busy_seen;
      f0 = ferr_seen;
      din = 1'b0;
      tick(4);
      din = 1'b1;
      tick(20);
      chk("glitch_busy_pulse", busy_seen > b0, 1);
      chk("glitch_idle", busy, 0);
      chk("glitch_nopush", fifo_count, 0);
      chk("glitch_noferr", ferr_seen - f0, 0);

      // framing error followed by a held-low line
      f0 = ferr_seen;
      send_frame(8'h3C, 1'b0);
      tick(40);
      chk("ferr_wait_busy", busy, 1);
      chk("ferr_once", ferr_seen - f0, 1);
      din = 1'b1;
      tick(5);
      chk("ferr_idle", busy, 0);
      chk("ferr_empty", fifo_count, 0);
      send_frame(8'h55, 1'b1);
      tick(4);
      pop_one(8'h55);

      // overrun on the fifth back-to-back frame
      o0 = ovr_seen;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      tick(4);
      chk("ovr_count", fifo_count, 4);
      chk("ovr_once", ovr_seen - o0, 1);
      for (int i = 1; i <= 4; i++) pop_one(8'(i));
      chk("ovr_drained", fifo_count, 0);

      // full FIFO with a pop in the stop-sample cycle
      o0 = ovr_seen;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
      send_frame(8'h05, 1'b1, 1'b1);
      tick(4);
      chk("fullpop_noovr", ovr_seen - o0, 0);
      chk("fullpop_count", fifo_count, 4);
      for (int i = 2; i <= 5; i++) pop_one(8'(i));
      chk("fullpop_drained", fifo_count, 0);

      // reset during bit 3 of 0xFF with a byte already queued
      send_frame(8'h99, 1'b1);
      tick(2);
      din = 1'b0;
      tick(BD);
      din = 1'b1;
      tick(3 * BD + HALF);
      chk("midrst_busy_before", busy, 1);
      rst = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", rx_valid, 0);
      chk("midrst_count", fifo_count, 0);
      chk("midrst_data", rx_data, 0);
      tick(3);
      rst = 1'b1;
      tick(3);
      send_frame(8'h81, 1'b1);
      tick(4);
      chk("midrst_count_after", fifo_count, 1);
      pop_one(8'h81);

      // random frames against a queue model
      q.delete();
      f0 = ferr_seen;
      o0 = ovr_seen;
      exp_f = 0;
      exp_o = 0;
      for (int r = 0; r < 24; r++) begin
         rb = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 3) != 0);
         send_frame(rb, good);
         if (!good) begin
            tick($urandom_range(0, 20));
            din = 1'b1;
            exp_f++;
         end else if (q.size() < DEPTH) begin
            q.push_back(rb);
         end else begin
            exp_o++;
         end
         tick(4);
         chk("rnd_count", fifo_count, q.size());
         chk("rnd_valid", rx_valid, q.size() != 0);
         n = $urandom_range(0, q.size());
         repeat (n) begin
            hb = q.pop_front();
            pop_one(hb);
         end
      end
      chk("rnd_ferr_total", ferr_seen - f0, exp_f);
      chk("rnd_ovr_total", ovr_seen - o0, exp_o);
      while (q.size() != 0) begin
         hb = q.pop_front();
         pop_one(hb);
      end
      chk("rnd_final_count", fifo_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receiver: 8N1 UART, LSB first, idle-high line; the receiving end for the frames our switch-driven transmitter sends on dout.
- Over-samples din on the system clock, samples each bit at mid-bit, checks the stop bit, and queues good bytes in a small FIFO.
- Consumers pop bytes through a valid/ready handshake. Planned consumers: display/LED logic and loopback tests.

Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz.
- BAUD, 9600: line rate in bit/s. BAUD_DIV = CLK_FREQ/BAUD (integer, truncated); HALF = BAUD_DIV/2.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  1  asynchronous serial input; idle = 1.
- rx_ready  in  1  consumer accepts the head byte this cycle.
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, async):
  - FSM = IDLE; both synchronizer flops = 1.
  - All counters and the shift register = 0; FIFO empty.
  - Outputs: rx_data=0, rx_valid=0, fifo_count=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame; no partial push.
- Input sync: din passes through 2 flops before any use (rxs). This adds 2 cycles of latency to all line timing.
- FSM states and transitions:
  - IDLE: when rxs=0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt=HALF-1:
    - rxs=0: go to DATA, cnt=0, bit_idx=0.
    - rxs=1: glitch; go to IDLE with no output.
  - DATA: at cnt=BAUD_DIV-1:
    - Sample rxs into shift[bit_idx] (LSB first), cnt=0, bit_idx+1.
    - After bit_idx=7 is sampled, go to STOP.
  - STOP: at cnt=BAUD_DIV-1, sample rxs:
    - rxs=1: push the byte (see FIFO rules), go to IDLE.
    - rxs=0: frame_err=1 for that one cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This stops a break condition from being taken as back-to-back frames.
- Back-to-back frames: IDLE is reached on the stop-bit sample cycle. A start edge arriving at the nominal end of the stop bit is therefore caught with no dead time.
- FIFO rules:
  - Storage is circular, with DEPTH entries and wrapping read/write pointers; fifo_count is held explicitly.
  - Pop = rx_valid & rx_ready.
  - Push = good stop bit and (count<DEPTH or pop in the same cycle).
  - Good stop bit while count=DEPTH and no pop: byte dropped, overrun=1 for one cycle, FIFO unchanged.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - rx_data is the entry at the read pointer (combinational from storage). It is 0 after reset until the first push.
  - A pushed byte appears with rx_valid=1 on the cycle after the stop-bit sample.
  - rx_ready while empty has no effect.
- Arithmetic:
  - cnt is wide enough for BAUD_DIV-1 and wraps only via explicit clear.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- busy = (state != IDLE).

Test Plan:
- Single byte, CLK_FREQ=16_000_000, BAUD=1_000_000 (BAUD_DIV=16, HALF=8): drive frame 0xA5 -> rx_valid rises 1 cycle after the stop sample, rx_data=0xA5, fifo_count=1. Then rx_ready=1 for 1 cycle -> rx_valid=0, fifo_count=0.
- Glitch: din low for 4 clocks, then high -> busy pulses, FSM returns to IDLE, no push, no frame_err.
- Framing error: send 0x3C with stop=0, hold din low 40 clocks, then high -> frame_err pulses exactly once, FIFO empty. The FSM stays in WAIT_HIGH until din=1. A following good 0x55 is received correctly.
- Overrun: rx_ready=0, send 0x01,0x02,0x03,0x04,0x05 back-to-back -> fifo_count=4, overrun pulses once on the 5th stop sample. Popping then yields 0x01..0x04 in order.
- Full plus simultaneous pop: FIFO full, rx_ready=1 on the 5th stop-sample cycle -> no overrun, 0x01 popped, 0x05 stored, count stays 4.
- Reset mid-frame: assert rst=0 during bit 3 of 0xFF -> all outputs 0 immediately. After release, a new 0x81 frame is received intact.
